// File: rtl/fp_accumulator.sv
// Sequential FP32 accumulator: sums `len` products through a WAIT/ALIGN/ADD/NORM FSM.
// Truncating and flush-to-zero. Define FPACC_RELU_EN to clamp negative results to +0 on output.
module fp_accumulator #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_data,
  output logic             busy,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [XLEN-1:0]  acc;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  operand;

  logic             bypass;
  logic [XLEN-1:0]  bypass_val;
  logic             big_sign;
  logic [7:0]       big_exp;
  logic [23:0]      big_man;
  logic             small_sign;
  logic [23:0]      small_man;
  logic [24:0]      sum_man;

  logic [7:0]       acc_exp, op_exp, exp_diff;
  logic [23:0]      acc_man, op_man, small_raw, small_aligned;
  logic             acc_larger;
  logic [24:0]      add_sum;
  logic [4:0]       lz;
  logic [8:0]       exp_inc;
  logic [22:0]      norm_shifted;
  logic [XLEN-1:0]  norm_result;

  // Leading-zero count of a 24-bit mantissa; the highest set bit wins.
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    n = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (v[i]) n = 5'(23 - i);
    end
    return n;
  endfunction

  function automatic logic [XLEN-1:0] relu(input logic [XLEN-1:0] v);
`ifdef FPACC_RELU_EN
    return v[XLEN-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        out_valid = (state == S_DONE);
        if (start) state_next = (len == '0) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_next = S_ALIGN;
      end
      S_ALIGN: begin
        busy       = 1'b1;
        state_next = S_ADD;
      end
      S_ADD: begin
        busy       = 1'b1;
        state_next = S_NORM;
      end
      S_NORM: begin
        busy       = 1'b1;
        state_next = (count == CNT_W'(1)) ? S_DONE : S_WAIT;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Alignment: the larger magnitude keeps its mantissa, the other is shifted down.
  always_comb begin
    acc_exp    = acc[30:23];
    op_exp     = operand[30:23];
    acc_man    = {1'b1, acc[22:0]};
    op_man     = {1'b1, operand[22:0]};
    acc_larger = (acc_exp > op_exp) || ((acc_exp == op_exp) && (acc_man >= op_man));
    if (acc_larger) begin
      exp_diff  = acc_exp - op_exp;
      small_raw = op_man;
    end else begin
      exp_diff  = op_exp - acc_exp;
      small_raw = acc_man;
    end
    small_aligned = (exp_diff >= 8'd25) ? 24'd0 : (small_raw >> exp_diff);
  end

  always_comb begin
    if (big_sign == small_sign) add_sum = {1'b0, big_man} + {1'b0, small_man};
    else                        add_sum = {1'b0, big_man} - {1'b0, small_man};
  end

  // Normalisation with saturation on overflow and flush-to-zero on underflow.
  always_comb begin
    lz           = lzc24(sum_man[23:0]);
    exp_inc      = {1'b0, big_exp} + 9'd1;
    norm_shifted = sum_man[22:0] << lz;
    norm_result  = '0;
    if (bypass) begin
      norm_result = bypass_val;
    end else if (sum_man == 25'd0) begin
      norm_result = '0;
    end else if (sum_man[24]) begin
      if (exp_inc >= 9'd255) norm_result = {big_sign, 8'hFE, 23'h7FFFFF};
      else                   norm_result = {big_sign, exp_inc[7:0], sum_man[23:1]};
    end else if ({3'b000, lz} >= big_exp) begin
      norm_result = '0;
    end else begin
      norm_result = {big_sign, big_exp - {3'b000, lz}, norm_shifted};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      count      <= '0;
      operand    <= '0;
      bypass     <= 1'b0;
      bypass_val <= '0;
      big_sign   <= 1'b0;
      big_exp    <= '0;
      big_man    <= '0;
      small_sign <= 1'b0;
      small_man  <= '0;
      sum_man    <= '0;
      out_data   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            acc   <= '0;
            count <= len;
            if (len == '0) out_data <= '0;
          end
        end
        S_WAIT: begin
          if (in_valid) operand <= in_data;
        end
        S_ALIGN: begin
          // A zero operand (exponent field 0) leaves the other operand untouched.
          bypass     <= (acc_exp == 8'd0) || (op_exp == 8'd0);
          bypass_val <= (op_exp == 8'd0) ? acc : operand;
          big_sign   <= acc_larger ? acc[31] : operand[31];
          big_exp    <= acc_larger ? acc_exp : op_exp;
          big_man    <= acc_larger ? acc_man : op_man;
          small_sign <= acc_larger ? operand[31] : acc[31];
          small_man  <= small_aligned;
        end
        S_ADD: begin
          sum_man <= add_sum;
        end
        S_NORM: begin
          acc   <= norm_result;
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) out_data <= relu(norm_result);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_accumulator.sv
// Scoreboard bench for fp_accumulator: expectations queued at start, checked when out_valid rises.
// Expected results for negative sums follow FPACC_RELU_EN when it is defined.
module tb_fp_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        busy;
  logic        out_valid;
  logic [31:0] out_data;

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          start_cycle;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] term_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cycle_cnt = 0;
  int          results_seen = 0;
  int          results_expected = 0;
  logic        prev_ov = 1'b0;
  logic        busy_seen = 1'b0;
  int          xfers;

  int pat_v[10]    = '{1, 0, 0, 1, 0, 1, 0, 1, 1, 0};
  int exp_rdy[10]  = '{1, 0, 0, 0, 1, 1, 0, 0, 0, 0};
  int exp_busy[10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};

`ifdef FPACC_RELU_EN
  localparam logic [31:0] NEG_SUM = 32'h00000000;
`else
  localparam logic [31:0] NEG_SUM = 32'hC0400000;
`endif

  fp_accumulator #(.XLEN(32), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .busy      (busy),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt++;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Monitor: pop one expectation per rising edge of out_valid.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && !prev_ov) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_result", out_data, 32'hFFFFFFFF);
      end else begin
        e = sb_q.pop_front();
        checkOutput("out_data", out_data, e.data);
        if (e.lat >= 0) checkOutput("latency", cycle_cnt - e.start_cycle, e.lat);
      end
      results_seen++;
    end
    prev_ov = out_valid;
    if (busy) busy_seen = 1'b1;
  end

  task automatic pushExpected(input logic [31:0] data, input int lat);
    exp_t e;
    e.data        = data;
    e.lat         = lat;
    e.start_cycle = cycle_cnt;
    sb_q.push_back(e);
    results_expected++;
  endtask

  task automatic waitResult();
    int n = 0;
    while (results_seen < results_expected && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (results_seen < results_expected) checkOutput("result_timeout", results_seen, results_expected);
  endtask

  // Starts a run over term_q with in_valid held high whenever a term is pending.
  task automatic applyStimulus(input logic [7:0] n, input logic [31:0] exp_data, input int exp_lat);
    int k;
    @(negedge clk);
    pushExpected(exp_data, exp_lat);
    start    = 1'b1;
    len      = n;
    in_valid = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < term_q.size(); i++) begin
      in_valid = 1'b1;
      in_data  = term_q[i];
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 50) begin
        @(negedge clk);
        k++;
      end
      if (!in_ready) begin
        checkOutput("ready_timeout", 32'd0, 32'd1);
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    term_q.delete();
    waitResult();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    len      = 8'd0;
    in_valid = 1'b0;
    in_data  = 32'd0;
    #1;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    busy_seen = 1'b0;
    applyStimulus(8'd0, 32'h00000000, 1);
    checkOutput("len0_busy_never", {31'd0, busy_seen}, 32'd0);

    term_q = '{32'h3F800000, 32'h40000000, 32'h3F000000};
    applyStimulus(8'd3, 32'h40600000, 13);
    repeat (3) @(negedge clk);
    checkOutput("hold_data", out_data, 32'h40600000);
    checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);

    term_q = '{32'h3F800000, 32'hBF800000};
    applyStimulus(8'd2, 32'h00000000, 9);

    term_q = '{32'h4B800000, 32'h3F800000};
    applyStimulus(8'd2, 32'h4B800000, 9);

    term_q = '{32'h7F000000, 32'h7F000000};
    applyStimulus(8'd2, 32'h7F7FFFFF, 9);

    term_q = '{32'h3F800000, 32'h00123456};
    applyStimulus(8'd2, 32'h3F800000, 9);

    term_q = '{32'h00800000, 32'h80C00000};
    applyStimulus(8'd2, 32'h00000000, 9);

    term_q = '{32'h3F800000, 32'h33000000};
    applyStimulus(8'd2, 32'h3F800000, 9);

    term_q = '{32'h3F800000, 32'hBE800000};
    applyStimulus(8'd2, 32'h3F400000, 9);

    term_q = '{32'hBF800000, 32'hC0000000};
    applyStimulus(8'd2, NEG_SUM, 9);

    // Handshake: gapped in_valid plus a start pulse that lands in ADD.
    xfers = 0;
    @(negedge clk);
    pushExpected(32'h40400000, 10);
    start    = 1'b1;
    len      = 8'd2;
    in_valid = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      #1;
      in_valid = pat_v[c-1][0];
      in_data  = (xfers == 0) ? 32'h3F800000 : 32'h40000000;
      start    = (c == 3);
      len      = (c == 3) ? 8'd1 : 8'd2;
      @(negedge clk);
      checkOutput($sformatf("hs_ready_c%0d", c), {31'd0, in_ready}, exp_rdy[c-1]);
      checkOutput($sformatf("hs_busy_c%0d", c), {31'd0, busy}, exp_busy[c-1]);
      if (in_valid && in_ready) xfers++;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    start    = 1'b0;
    checkOutput("hs_transfers", xfers, 32'd2);
    waitResult();

    // Reset while the second term is in ADD, then a fresh one-term run.
    @(negedge clk);
    start    = 1'b1;
    len      = 8'd2;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h3F800000;
    @(posedge clk);
    #1 in_data = 32'h40000000;
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_out_data", out_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    term_q = '{32'h40400000};
    applyStimulus(8'd1, 32'h40400000, 5);

    repeat (2) @(negedge clk);
    checkOutput("sb_empty", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_accumulator.md
Name: fp_accumulator

Overview:
- Sequential FP32 accumulator that sits directly downstream of the FP32 multiplier in the neuron datapath.
- Consumes a stream of products over a valid/ready handshake and sums exactly `len` of them into one FP32 result (the neuron pre-activation).
- Uses a multi-cycle align/add/normalize FSM.
- Numeric conventions match the multiplier: IEEE-754 single-precision layout, truncation (no rounding), no denormal/NaN/Inf support.

Parameters:
- XLEN, 32, data width; only 32 is supported.
- CNT_W, 8, width of the term-count input; max terms = 2^CNT_W - 1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  clears accumulator to +0 and loads len; honoured only in IDLE or DONE.
- len  input  CNT_W  number of terms to accumulate; sampled when start is honoured.
- in_valid  input  1  in_data holds a valid product.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  XLEN  FP32 product from the multiplier.
- busy  output  1  high in WAIT, ALIGN, ADD, NORM.
- out_valid  output  1  result available; high for the whole time the FSM is in DONE.
- out_data  output  XLEN  accumulated FP32 sum; registered.

Behaviour:
- Reset values (any time rst_n=0, including mid-operation): state IDLE; accumulator=0; count=0; in_ready=0; busy=0; out_valid=0; out_data=0. All in-flight work is discarded.
- States and transitions:
  - IDLE: start → WAIT if len≠0, else DONE with accumulator +0.
  - WAIT: in_ready=1. On in_valid&&in_ready, capture in_data → ALIGN.
  - ALIGN: pick the larger-exponent operand; shift the smaller 24-bit mantissa (hidden 1 restored) right by the exponent difference; difference ≥25 gives zero contribution. → ADD.
  - ADD: equal signs add mantissas (25-bit result). Unequal signs subtract smaller magnitude from larger; result takes the sign of the larger; equal magnitudes give +0 (all zeros). → NORM.
  - NORM: single cycle. Carry out → shift right 1, exponent+1. Otherwise left-shift by leading-zero count (combinational LZC) until bit 23 is set, decreasing the exponent by the same amount. Write back to the accumulator; count−1. If count reaches 0 → DONE, else → WAIT.
  - DONE: out_data loaded on entry; out_valid=1 and out_data held until the next start. start in DONE behaves as in IDLE (next cycle: out_valid=0).
- Zero handling: an operand with exponent field 0 is treated as zero regardless of mantissa; the sum is then the other operand unchanged.
- Exponent underflow: normalized exponent ≤0 flushes the result to +0 (0x00000000).
- Exponent overflow: exponent ≥255 saturates to max finite, {sign, 8'hFE, 23'h7FFFFF}.
- Latency:
  - Minimum 4 cycles per term (WAIT, ALIGN, ADD, NORM).
  - With in_valid held high, out_valid rises 4·len+1 cycles after the start cycle.
  - len=0: out_valid rises 1 cycle after start.
- Handshake rules:
  - in_ready=0 outside WAIT; in_valid outside WAIT is ignored and nothing is consumed.
  - in_data must stay stable while in_valid=1 and in_ready=0.
- start while busy is ignored.

Optional Feature:
- Macro FPACC_RELU_EN.
- Defined: ReLU applied when loading out_data in DONE; a negative result (sign=1) is replaced by 0x00000000. The internal accumulator is unaffected.
- Undefined: out_data = raw accumulator value.

Test Plan:
- len=3; inputs 0x3F800000, 0x40000000, 0x3F000000 (1.0, 2.0, 0.5), in_valid held high → out_data=0x40600000 (3.5); out_valid 13 cycles after start.
- len=2; inputs 0x3F800000, 0xBF800000 → out_data=0x00000000. Separately, len=0 → out_data=0x00000000, out_valid 1 cycle after start, busy never high.
- len=2; inputs 0x4B800000, 0x3F800000 (2^24 + 1.0) → 0x4B800000 (truncated). Separately, 0x7F000000+0x7F000000 → 0x7F7FFFFF (saturation).
- Handshake: in_valid toggles 1,0,0,1 with len=2 → exactly 2 transfers, in_ready high only in WAIT; start pulsed during ADD is ignored.
- Reset mid-op: rst_n low during ADD of term 2 → outputs immediately 0, state IDLE. A new start with len=1 and input 0x40400000 → out_data=0x40400000.
- len=2; inputs 0xBF800000, 0xC0000000 → out_data=0xC0400000 without FPACC_RELU_EN, 0x00000000 with it.
